// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, state type and size helper for the sized data memory
package dmem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Request fields captured at acceptance; the address is kept separately
    // because its width depends on the array depth.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] data;
    } req_t;

    // Reserved size reports zero bytes; it is rejected before any use.
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store placement and load extraction/extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] word_rd,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [4:0]  shift;
    logic [31:0] shifted;

    assign shift   = {addr_lo, 3'b000};
    assign wdata   = store_data << shift;
    assign shifted = word_rd >> shift;

    always_comb begin
        be = 4'b0000;
        case (size)
            SIZE_B:  be = 4'b0001 << addr_lo;
            SIZE_H:  be = 4'b0011 << addr_lo;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        load_data = '0;
        case (size)
            SIZE_B:  load_data = uns ? {24'h000000, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_data = uns ? {16'h0000, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_W:  load_data = word_rd;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - little-endian byte/half/word memory with wait states and error reporting
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [31:0]       data_o,
    output logic              err_o
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WAW   = (AW > 2) ? AW - 2 : 1;

    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH_BYTES);

    state_t          state;
    logic [3:0]      cnt;
    req_t            lreq;
    logic [AW-1:0]   laddr;

    logic [31:0]     mem [WORDS];

    logic [ADDR_W:0] end_addr;
    logic            illegal;
    logic            accept;
    logic            commit;
    logic [WAW-1:0]  word_idx;
    logic [31:0]     rd_word;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     load_data;

    // One extra bit so addresses near the top of the address space cannot wrap.
    assign end_addr = {1'b0, addr_i} + (ADDR_W + 1)'(bytes_of(size_i));

    assign illegal = (size_i == SIZE_RSV)
                   | ((size_i == SIZE_H) & addr_i[0])
                   | ((size_i == SIZE_W) & (addr_i[1:0] != 2'b00))
                   | (end_addr > DEPTH_X);

    // The request present while valid_o is high is the one just finished.
    assign accept  = (state == IDLE) & req_i & ~valid_o;
    assign commit  = (state == BUSY) & (cnt == 4'd0);
    assign stall_o = (state == BUSY) | accept;

    assign word_idx = WAW'(laddr >> 2);
    assign rd_word  = mem[word_idx];

    dmem_lane_align u_lane_align (
        .size       (lreq.size),
        .uns        (lreq.uns),
        .addr_lo    (laddr[1:0]),
        .store_data (lreq.data),
        .word_rd    (rd_word),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            valid_o <= 1'b1;
                            err_o   <= 1'b1;
                            data_o  <= '0;
                        end else begin
                            lreq.we   <= we_i;
                            lreq.size <= size_i;
                            lreq.uns  <= unsigned_i;
                            lreq.data <= data_i;
                            laddr     <= addr_i[AW-1:0];
                            cnt       <= CNT_INIT;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        valid_o <= 1'b1;
                        data_o  <= lreq.we ? 32'h0 : load_data;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (commit && lreq.we && !rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised, clocked successor to the single-cycle word data memory.
- Little-endian byte array supporting byte, half and word accesses, with signed or unsigned load extension.
- Configurable wait-state latency with a stall/valid handshake toward the MEM stage of the CPU pipeline.
- Detects misaligned and out-of-range accesses and reports them instead of corrupting memory.

Parameters:
DEPTH_BYTES, 1024, array size in bytes; must be a power of two and at least 4.
LATENCY, 1, number of BUSY cycles per legal access; legal range 1..16.
ADDR_W, 32, width of addr_i.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
req_i  in  1  access request; held by the pipeline while stall_o=1.
we_i  in  1  1=store, 0=load.
size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (illegal).
unsigned_i  in  1  load extension: 1=zero-extend, 0=sign-extend. Ignored on stores.
addr_i  in  ADDR_W  byte address.
data_i  in  32  store data, low-aligned: byte uses [7:0], half uses [15:0].
stall_o  out  1  combinational; high while the request has not completed.
valid_o  out  1  registered one-cycle completion pulse.
data_o  out  32  load result, extended to 32 bits; 0 for stores and errors.
err_o  out  1  registered; high together with valid_o when the access was illegal.

Behaviour:
- Reset: synchronous, active high. State goes to IDLE, counter to 0, valid_o/err_o/data_o to 0. Array contents are not reset.
- Reset mid-access: the pending access is dropped and any pending store is never committed. Reset wins over a commit on the same edge.
- Legality:
  - Illegal if size_i=11.
  - Illegal if half and addr_i[0]=1.
  - Illegal if word and addr_i[1:0]!=0.
  - Illegal if addr_i + bytes > DEPTH_BYTES. Compute this in ADDR_W+1 bits so it cannot wrap.
- stall_o = (state==BUSY) | (state==IDLE & req_i & ~valid_o).
  - A request seen in the cycle valid_o is high is the one just completed and is not re-accepted.
- IDLE, req_i=1, valid_o=0, legal access:
  - Latch we/size/unsigned/addr/data.
  - cnt <= LATENCY-1; go to BUSY.
- IDLE, req_i=1, valid_o=0, illegal access:
  - Stay in IDLE.
  - Next cycle: valid_o=1, err_o=1, data_o=0. No array write.
- BUSY, cnt!=0: decrement cnt.
- BUSY, cnt==0, at the clock edge:
  - Store: commit bytes to the array, little endian (data_i[7:0] to addr, [15:8] to addr+1, and so on).
  - Load: register the extended result into data_o.
  - Set valid_o=1, err_o=0; return to IDLE.
- Timing: request in cycle 0 gives stall_o high in cycles 0..LATENCY and valid_o in cycle LATENCY+1. valid_o is always exactly one cycle wide.
- Back-to-back: a new request is accepted in the cycle after valid_o. Minimum spacing is LATENCY+2 cycles per access.
- Load data: read from the array on the commit edge, so a load sees every earlier committed store.
- Extension: signed byte replicates bit 7; signed half replicates bit 15; word ignores unsigned_i.
- Inputs are sampled only in IDLE at acceptance. Input changes during BUSY have no effect.
- Outputs other than stall_o hold their value outside valid cycles: data_o keeps the last value, err_o returns to 0.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SIZE_B, SIZE_H, SIZE_W, SIZE_RSV.
  - State enum {IDLE, BUSY}.
  - Function bytes_of(size).
- One natural combinational sub-module, dmem_lane_align:
  - Inputs: size, unsigned flag, addr[1:0].
  - Outputs: byte-lane write enables and load extraction/extension.
  - Keeps the FSM module free of lane muxing.

Test Plan:
1. LATENCY=1: store word 0xDEADBEEF @0x10 -> stall_o high 2 cycles, valid_o in cycle 2, err_o=0. Then load word unsigned @0x10 -> data_o=0xDEADBEEF.
2. Store byte 0x80 @0x21, then signed load byte @0x21 -> 0xFFFFFF80; unsigned load byte -> 0x00000080; load half @0x20 with the other byte 0x00 -> signed 0xFFFF8000.
3. Illegal accesses: load word @0x12, store half @0x13, size_i=11, word @DEPTH_BYTES-2 -> each gives valid_o=err_o=1 one cycle after request, data_o=0, and the array is unchanged (checked by a later read).
4. LATENCY=4: two back-to-back loads with req_i held -> stall_o high cycles 0..4, valid_o at 5; second accepted at 6, valid_o at 11; no duplicate acceptance.
5. rst_i asserted in the second BUSY cycle of a LATENCY=4 store of 0x11223344 @0x40 -> outputs 0 next cycle, state IDLE; a subsequent load @0x40 returns the prior contents.
6. Store half 0xA5A5 @0x30, then modify data_i/addr_i during BUSY -> the stored value and address match the values latched at acceptance.
